// File: rtl/pc_redirect_controller.sv
// -----------------------------------------------------------------------------
// pc_redirect_controller
//
// Turns a taken branch/jump resolved in EX into a single-cycle PC redirect and
// IF/ID + ID/EX flush. A redirect seen while the pipeline is stalled is held
// in PENDING until the stall clears, so the pulse never lands on a frozen
// pipeline. Only one redirect can be outstanding at a time.
//
// States: RUN -> (REDIRECT | PENDING); PENDING -> REDIRECT; REDIRECT -> RUN.
//
// Ports
//   CLK             in   1  clock, all state on rising edge
//   RESET_N         in   1  synchronous active-low reset
//   EX_VALID        in   1  EX holds a real (non-bubble) instruction
//   BRANCH_JUMP     in   3  branch/jump class of the EX instruction
//   PC_SEL          in   1  taken decision for the EX instruction
//   TARGET_ADDR     in  32  branch/jump target computed in EX
//   STALL_REQ       in   1  pipeline frozen this cycle
//   PC_LOAD         out  1  one-cycle pulse: PC loads PC_NEXT
//   PC_NEXT         out 32  registered redirect address
//   FLUSH_IF_ID     out  1  bubble the IF/ID register
//   FLUSH_ID_EX     out  1  bubble the ID/EX register
//   BUSY            out  1  high in any state other than RUN
//   BJ_EVAL_COUNT   out 32  (BJ_STATS_EN only) evaluated branches, saturating
//   BJ_TAKEN_COUNT  out 32  (BJ_STATS_EN only) redirects issued, saturating
//
// Optional feature: define BJ_STATS_EN to add the two statistics counters.
// -----------------------------------------------------------------------------
module pc_redirect_controller (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        EX_VALID,
    input  logic [2:0]  BRANCH_JUMP,
    input  logic        PC_SEL,
    input  logic [31:0] TARGET_ADDR,
    input  logic        STALL_REQ,
    output logic        PC_LOAD,
    output logic [31:0] PC_NEXT,
    output logic        FLUSH_IF_ID,
    output logic        FLUSH_ID_EX,
    output logic        BUSY
`ifdef BJ_STATS_EN
    ,
    output logic [31:0] BJ_EVAL_COUNT,
    output logic [31:0] BJ_TAKEN_COUNT
`endif
);

    // Value of the `NO macro from encodings.v (not a branch or jump).
    localparam logic [2:0] BJ_NO = 3'b000;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_PENDING  = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_next_q, pc_next_d;
    logic        is_bj;
    logic        detect;

    assign is_bj  = (BRANCH_JUMP != BJ_NO);
    assign detect = (state_q == ST_RUN) && EX_VALID && is_bj && PC_SEL;

    // Next-state logic. The target is captured only at detection, so PENDING
    // keeps the original target even if EX moves on or TARGET_ADDR changes.
    always_comb begin
        state_d   = state_q;
        pc_next_d = pc_next_q;
        case (state_q)
            ST_RUN: begin
                if (detect) begin
                    pc_next_d = TARGET_ADDR;
                    state_d   = STALL_REQ ? ST_PENDING : ST_REDIRECT;
                end
            end
            ST_PENDING: begin
                if (!STALL_REQ) begin
                    state_d = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                // Flush wins over stall downstream, so the pulse is never held.
                state_d = ST_RUN;
            end
            default: begin
                // Unused encoding: fall back to RUN without issuing a redirect.
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q   <= ST_RUN;
            pc_next_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_next_q <= pc_next_d;
        end
    end

    // Outputs decode straight from the state register, so they are glitch-free
    // and exactly one cycle wide in REDIRECT.
    assign PC_LOAD     = (state_q == ST_REDIRECT);
    assign FLUSH_IF_ID = (state_q == ST_REDIRECT);
    assign FLUSH_ID_EX = (state_q == ST_REDIRECT);
    assign BUSY        = (state_q != ST_RUN);
    assign PC_NEXT     = pc_next_q;

`ifdef BJ_STATS_EN
    logic [31:0] eval_cnt_q;
    logic [31:0] taken_cnt_q;
    logic        eval_inc;
    logic        taken_inc;

    // A branch counts as evaluated only when EX actually advances in RUN.
    assign eval_inc  = (state_q == ST_RUN) && EX_VALID && is_bj && !STALL_REQ;
    assign taken_inc = (state_d == ST_REDIRECT) && (state_q != ST_REDIRECT);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            eval_cnt_q  <= 32'h0;
            taken_cnt_q <= 32'h0;
        end else begin
            if (eval_inc && (eval_cnt_q != 32'hFFFF_FFFF)) begin
                eval_cnt_q <= eval_cnt_q + 32'd1;
            end
            if (taken_inc && (taken_cnt_q != 32'hFFFF_FFFF)) begin
                taken_cnt_q <= taken_cnt_q + 32'd1;
            end
        end
    end

    assign BJ_EVAL_COUNT  = eval_cnt_q;
    assign BJ_TAKEN_COUNT = taken_cnt_q;
`else
    // Statistics build option off: no counters and no extra ports.
`endif

endmodule
